// File: rtl/eth_pkg.sv
// Shared constants and FSM encodings for the Ethernet receive frame buffer.
package eth_pkg;

  localparam int MIN_FRAME   = 18;
  localparam int MAX_FRAME   = 1518;
  localparam int FCS_LEN     = 4;
  localparam int CRC_TIMEOUT = 8;
  localparam int LEN_W       = 11;  // wide enough for MAX_FRAME

  typedef enum logic [2:0] {
    W_IDLE,
    W_FRAME,
    W_WAIT_CRC,
    W_COMMIT,
    W_DROP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_STREAM
  } r_state_t;

endpackage

// File: rtl/eth_rx_buf_ram.sv
// Simple dual-port frame-data RAM: one write port, one registered read port.
module eth_rx_buf_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  // NOTE: the array itself is not reset so it maps onto block RAM; only the read register is.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/eth_rx_frame_buf.sv
// Receive frame buffer: stores frames speculatively, commits CRC-good ones, streams them out.
module eth_rx_frame_buf
  import eth_pkg::*;
#(
  parameter int pAddr_Width     = 11,
  parameter int pLen_Depth_Log2 = 2
) (
  input  logic        Clk,
  input  logic        Rst_N,
  input  logic        Rx_En,
  input  logic        Byte_Rdy,
  input  logic [7:0]  Byte,
  input  logic        Crc_Valid,
  output logic [7:0]  M_Tdata,
  output logic        M_Tvalid,
  output logic        M_Tlast,
  input  logic        M_Tready,
  output logic        Frame_Commit,
  output logic        Frame_Drop,
  output logic [15:0] Drop_Cnt
);

  localparam int DEPTH    = 1 << pAddr_Width;
  localparam int LQ_DEPTH = 1 << pLen_Depth_Log2;
  localparam int OCC_W    = pLen_Depth_Log2 + 1;

  typedef logic [pAddr_Width-1:0] addr_t;
  typedef logic [LEN_W-1:0]       len_t;

  w_state_t w_state;
  r_state_t r_state;

  logic  rx_en_q, rx_rise;
  addr_t spec_ptr, commit_ptr, rd_ptr, rd_ptr_nxt, used;
  len_t  byte_cnt, frame_len, remain, head_len, next_len;
  logic  err;
  logic [3:0] to_cnt;

  len_t len_q [LQ_DEPTH];
  logic [pLen_Depth_Log2-1:0] lq_wr, lq_rd, lq_rd_nxt;
  logic [OCC_W-1:0] lq_occ;
  logic lq_full, push, pop, accept;

  logic  wr_byte, wr_ok, ram_re;
  addr_t ram_raddr;

  assign rx_rise    = Rx_En & ~rx_en_q;
  // Used space is measured from the oldest unconsumed byte to the speculative write point.
  assign used       = spec_ptr - rd_ptr;
  assign frame_len  = byte_cnt - LEN_W'(FCS_LEN);
  assign lq_full    = (lq_occ == OCC_W'(LQ_DEPTH));
  assign lq_rd_nxt  = lq_rd + 1'b1;
  assign rd_ptr_nxt = rd_ptr + 1'b1;
  assign head_len   = len_q[lq_rd];
  assign next_len   = len_q[lq_rd_nxt];
  assign push       = (w_state == W_COMMIT);
  assign accept     = M_Tvalid & M_Tready;
  assign pop        = (r_state == R_STREAM) & accept & (remain == LEN_W'(1));
  assign wr_byte    = (w_state == W_FRAME) & Rx_En & Byte_Rdy;
  assign wr_ok      = wr_byte & ~err & (byte_cnt != LEN_W'(MAX_FRAME))
                      & (used != addr_t'(DEPTH - 2));

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      w_state      <= W_IDLE;
      rx_en_q      <= 1'b0;
      spec_ptr     <= '0;
      commit_ptr   <= '0;
      byte_cnt     <= '0;
      err          <= 1'b0;
      to_cnt       <= '0;
      lq_wr        <= '0;
      Frame_Commit <= 1'b0;
      Frame_Drop   <= 1'b0;
      Drop_Cnt     <= '0;
    end else begin
      rx_en_q      <= Rx_En;
      Frame_Commit <= 1'b0;
      Frame_Drop   <= 1'b0;
      case (w_state)
        W_IDLE: begin
          if (rx_rise) begin
            spec_ptr <= commit_ptr;
            byte_cnt <= '0;
            err      <= lq_full;
            w_state  <= W_FRAME;
          end
        end
        W_FRAME: begin
          if (!Rx_En) begin
            to_cnt  <= '0;
            w_state <= W_WAIT_CRC;
          end else if (wr_ok) begin
            spec_ptr <= spec_ptr + 1'b1;
            byte_cnt <= byte_cnt + 1'b1;
          end else if (wr_byte) begin
            err <= 1'b1;
          end
        end
        W_WAIT_CRC: begin
          to_cnt <= to_cnt + 1'b1;
          if (Crc_Valid)
            w_state <= (!err && byte_cnt >= LEN_W'(MIN_FRAME)) ? W_COMMIT : W_DROP;
          else if (rx_rise || to_cnt == 4'(CRC_TIMEOUT - 1))
            w_state <= W_DROP;
        end
        W_COMMIT: begin
          lq_wr        <= lq_wr + 1'b1;
          commit_ptr   <= commit_ptr + addr_t'(frame_len);
          Frame_Commit <= 1'b1;
          w_state      <= W_IDLE;
        end
        W_DROP: begin
          Frame_Drop <= 1'b1;
          if (Drop_Cnt != 16'hFFFF) Drop_Cnt <= Drop_Cnt + 1'b1;
          if (Rx_En) begin
            spec_ptr <= commit_ptr;
            byte_cnt <= '0;
            err      <= lq_full;
            w_state  <= W_FRAME;
          end else begin
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (push) len_q[lq_wr] <= frame_len;
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      r_state  <= R_IDLE;
      rd_ptr   <= '0;
      remain   <= '0;
      lq_rd    <= '0;
      lq_occ   <= '0;
      M_Tvalid <= 1'b0;
      M_Tlast  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (lq_occ != '0) begin
            remain   <= head_len;
            M_Tvalid <= 1'b1;
            M_Tlast  <= (head_len == LEN_W'(1));
            r_state  <= R_STREAM;
          end
        end
        R_STREAM: begin
          if (accept) begin
            rd_ptr <= rd_ptr_nxt;
            if (remain == LEN_W'(1)) begin
              lq_rd <= lq_rd_nxt;
              // Chain straight into the next queued frame to keep one byte per cycle.
              if (lq_occ > OCC_W'(1)) begin
                remain  <= next_len;
                M_Tlast <= (next_len == LEN_W'(1));
              end else begin
                M_Tvalid <= 1'b0;
                M_Tlast  <= 1'b0;
                r_state  <= R_IDLE;
              end
            end else begin
              remain  <= remain - 1'b1;
              M_Tlast <= (remain == LEN_W'(2));
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
      if (push && !pop)      lq_occ <= lq_occ + 1'b1;
      else if (pop && !push) lq_occ <= lq_occ - 1'b1;
    end
  end

  // The read register only advances on acceptance, so a stalled byte holds on M_Tdata.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    ram_re    = 1'b0;
    ram_raddr = rd_ptr;
    if (r_state == R_IDLE) begin
      ram_re = (lq_occ != '0);
    end else if (accept) begin
      ram_re    = 1'b1;
      ram_raddr = rd_ptr_nxt;
    end
  end

  eth_rx_buf_ram #(
    .ADDR_W (pAddr_Width),
    .DATA_W (8)
  ) u_ram (
    .clk   (Clk),
    .rst_n (Rst_N),
    .we    (wr_ok),
    .waddr (spec_ptr),
    .wdata (Byte),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (M_Tdata)
  );

endmodule

// File: tb/tb_eth_rx_frame_buf.sv
// Directed self-checking bench for eth_rx_frame_buf: commit, drop, backpressure, reset.
`timescale 1ns/1ps
module tb_eth_rx_frame_buf;

  logic        Clk = 1'b0;
  logic        Rst_N = 1'b0;
  logic        Rx_En = 1'b0;
  logic        Byte_Rdy = 1'b0;
  logic [7:0]  Byte = 8'h00;
  logic        Crc_Valid = 1'b0;
  logic        M_Tready = 1'b0;
  logic [7:0]  M_Tdata;
  logic        M_Tvalid;
  logic        M_Tlast;
  logic        Frame_Commit;
  logic        Frame_Drop;
  logic [15:0] Drop_Cnt;

  always #5 Clk = ~Clk;

  eth_rx_frame_buf #(
    .pAddr_Width     (11),
    .pLen_Depth_Log2 (2)
  ) dut (
    .Clk          (Clk),
    .Rst_N        (Rst_N),
    .Rx_En        (Rx_En),
    .Byte_Rdy     (Byte_Rdy),
    .Byte         (Byte),
    .Crc_Valid    (Crc_Valid),
    .M_Tdata      (M_Tdata),
    .M_Tvalid     (M_Tvalid),
    .M_Tlast      (M_Tlast),
    .M_Tready     (M_Tready),
    .Frame_Commit (Frame_Commit),
    .Frame_Drop   (Frame_Drop),
    .Drop_Cnt     (Drop_Cnt)
  );

  int errors = 0;
  int checks = 0;

  // Monitor state, written only by the negedge monitor.
  int         cyc = 0;
  int         commit_cnt = 0;
  int         drop_pulses = 0;
  int         drop_cyc = 0;
  int         stall_err = 0;
  bit         held = 1'b0;
  logic [8:0] held_val = '0;
  logic [8:0] out_q [$];

  // Main-flow state.
  int rd_i = 0;
  int ready_mode = 0;
  int fall_cyc = 0;

  always @(negedge Clk) begin
    cyc++;
    if (!Rst_N) begin
      held = 1'b0;
    end else begin
      if (Frame_Commit) commit_cnt++;
      if (Frame_Drop) begin
        drop_pulses++;
        drop_cyc = cyc;
      end
      if (held && (!M_Tvalid || {M_Tlast, M_Tdata} !== held_val)) stall_err++;
      if (M_Tvalid && M_Tready) out_q.push_back({M_Tlast, M_Tdata});
      held     = M_Tvalid && !M_Tready;
      held_val = {M_Tlast, M_Tdata};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
    case (ready_mode)
      0:       M_Tready = 1'b0;
      1:       M_Tready = 1'b1;
      default: M_Tready = ~M_Tready;
    endcase
  endtask

  function automatic logic [7:0] pat(input int seed, input int i);
    return 8'((seed * 29 + i * 7 + (i >> 8)) & 255);
  endfunction

  task automatic send_frame(input int len, input int seed, input bit crc);
    Rx_En = 1'b1;
    tick();
    for (int i = 0; i < len; i++) begin
      Byte_Rdy = 1'b1;
      Byte     = pat(seed, i);
      tick();
    end
    Byte_Rdy = 1'b0;
    Rx_En    = 1'b0;
    fall_cyc = cyc;
    tick();
    tick();
    Crc_Valid = crc;
    tick();
    Crc_Valid = 1'b0;
    repeat (12) tick();
  endtask

  task automatic wait_out(input int n, input int budget);
    int k = 0;
    while ((out_q.size() - rd_i) < n && k < budget) begin
      tick();
      k++;
    end
  endtask

  task automatic check_frame(input string tag, input int len, input int seed);
    int avail = out_q.size() - rd_i;
    int n = (avail < len) ? avail : len;
    int bad = 0;
    int last_bad = 0;
    for (int i = 0; i < n; i++) begin
      logic [8:0] e;
      e = out_q[rd_i + i];
      if (e[7:0] !== pat(seed, i)) bad++;
      if (e[8] !== (i == len - 1)) last_bad++;
    end
    rd_i += n;
    check($sformatf("%s_count", tag), n, len);
    check($sformatf("%s_data", tag), bad, 0);
    check($sformatf("%s_tlast", tag), last_bad, 0);
  endtask

  task automatic do_reset();
    Rst_N = 1'b0;
    repeat (3) tick();
    Rst_N = 1'b1;
    tick();
    tick();
    rd_i = out_q.size();
  endtask

  initial begin
    int c_base;
    int d_base;
    int s_base;
    int delay;

    ready_mode = 0;
    Rst_N = 1'b0;
    repeat (3) tick();
    check("rst_tvalid", M_Tvalid, 0);
    check("rst_tlast", M_Tlast, 0);
    check("rst_tdata", M_Tdata, 0);
    check("rst_commit", Frame_Commit, 0);
    check("rst_drop", Frame_Drop, 0);
    check("rst_drop_cnt", Drop_Cnt, 0);
    Rst_N = 1'b1;
    tick();
    tick();

    // Good 64-byte frame, consumer always ready.
    ready_mode = 1;
    send_frame(64, 1, 1'b1);
    wait_out(60, 200);
    check_frame("good64", 60, 1);
    check("good64_commit", commit_cnt, 1);
    check("good64_drop_cnt", Drop_Cnt, 0);
    repeat (10) tick();
    check("good64_no_extra", out_q.size() - rd_i, 0);

    // Same frame without Crc_Valid: timeout drop.
    send_frame(64, 2, 1'b0);
    repeat (5) tick();
    check("nocrc_drop_pulses", drop_pulses, 1);
    delay = drop_cyc - fall_cyc;
    check("nocrc_drop_delay_ok", (delay >= 9 && delay <= 12), 1);
    check("nocrc_no_output", out_q.size() - rd_i, 0);
    check("nocrc_drop_cnt", Drop_Cnt, 1);
    check("nocrc_commit", commit_cnt, 1);

    // Minimum-length boundary: 17 bytes dropped, 18 bytes commit 14.
    send_frame(17, 3, 1'b1);
    check("len17_drop_cnt", Drop_Cnt, 2);
    send_frame(18, 4, 1'b1);
    wait_out(14, 100);
    check_frame("len18", 14, 4);

    // Queue full: five frames with consumer stalled, fifth dropped.
    do_reset();
    check("q_rst_drop_cnt", Drop_Cnt, 0);
    c_base = commit_cnt;
    ready_mode = 0;
    tick();
    for (int f = 0; f < 5; f++) send_frame(64, 10 + f, 1'b1);
    check("qfull_drop_cnt", Drop_Cnt, 1);
    check("qfull_commits", commit_cnt - c_base, 4);
    check("qfull_tvalid_stalled", M_Tvalid, 1);
    check("qfull_nothing_out", out_q.size() - rd_i, 0);
    ready_mode = 1;
    wait_out(240, 600);
    for (int f = 0; f < 4; f++) check_frame($sformatf("qfull_f%0d", f), 60, 10 + f);
    repeat (10) tick();
    check("qfull_no_extra", out_q.size() - rd_i, 0);

    // Oversize frame dropped, next frame intact.
    send_frame(1600, 20, 1'b1);
    check("big_drop_cnt", Drop_Cnt, 2);
    send_frame(100, 21, 1'b1);
    wait_out(96, 300);
    check_frame("after_big", 96, 21);

    // Consumer toggling ready every cycle.
    s_base = stall_err;
    ready_mode = 2;
    send_frame(64, 30, 1'b1);
    wait_out(60, 400);
    check_frame("toggle", 60, 30);
    check("toggle_stable", stall_err - s_base, 0);
    ready_mode = 1;
    repeat (10) tick();
    check("toggle_no_extra", out_q.size() - rd_i, 0);

    // Reset in the middle of a readout.
    ready_mode = 0;
    send_frame(64, 40, 1'b1);
    ready_mode = 1;
    repeat (20) tick();
    check("midrst_streaming", M_Tvalid, 1);
    d_base = drop_pulses;
    Rst_N = 1'b0;
    #1;
    check("midrst_tvalid_now", M_Tvalid, 0);
    check("midrst_tdata_now", M_Tdata, 0);
    repeat (3) tick();
    Rst_N = 1'b1;
    tick();
    tick();
    check("midrst_no_drop_pulse", drop_pulses - d_base, 0);
    check("midrst_drop_cnt", Drop_Cnt, 0);
    rd_i = out_q.size();
    send_frame(64, 41, 1'b1);
    wait_out(60, 200);
    check_frame("post_rst", 60, 41);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
